// File: rtl/seg7_display_scan_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg7_display_scan_pkg;

   localparam int SCAN_DIV_DEFAULT = 50000;
   localparam int SCAN_DIGITS      = 8;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [7:0] AN_OFF    = 8'hFF;

   // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
   localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
   localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
   localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
   localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
   localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
   localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
   localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
   localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
   localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
   localparam logic [6:0] SEG_HEX_A = 7'b0001000;
   localparam logic [6:0] SEG_HEX_B = 7'b0000011;
   localparam logic [6:0] SEG_HEX_C = 7'b1000110;
   localparam logic [6:0] SEG_HEX_D = 7'b0100001;
   localparam logic [6:0] SEG_HEX_E = 7'b0000110;
   localparam logic [6:0] SEG_HEX_F = 7'b0001110;

   // A digit above 0 is a leading zero when it and every more significant nibble are zero
   function automatic logic lz_blank(input logic [31:0] data, input logic [2:0] idx,
                                     input logic en);
      return en && (idx != 3'd0) && ((data >> {idx, 2'b00}) == 32'd0);
   endfunction

endpackage

// File: rtl/seg7_display_scan_if.sv
// Display value in, board pin drive out.
interface seg7_display_scan_if;

   logic [31:0] display_data;
   logic [7:0]  dp_mask;
   logic        blank_lz;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   // master: the I/O block supplying the value; slave: the scan driver
   modport master (output display_data, dp_mask, blank_lz,
                   input  an, seg, dp, frame_done);
   modport slave  (input  display_data, dp_mask, blank_lz,
                   output an, seg, dp, frame_done);

endinterface

// File: rtl/seg7_hex_decoder.sv
// Nibble to active-low seven-segment pattern.
module seg7_hex_decoder
   import seg7_display_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   // Pure lookup of the hex glyph
   always_comb begin
      // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
      pattern = SEG_BLANK;
      case (nibble)
         4'h0: pattern = SEG_HEX_0;
         4'h1: pattern = SEG_HEX_1;
         4'h2: pattern = SEG_HEX_2;
         4'h3: pattern = SEG_HEX_3;
         4'h4: pattern = SEG_HEX_4;
         4'h5: pattern = SEG_HEX_5;
         4'h6: pattern = SEG_HEX_6;
         4'h7: pattern = SEG_HEX_7;
         4'h8: pattern = SEG_HEX_8;
         4'h9: pattern = SEG_HEX_9;
         4'hA: pattern = SEG_HEX_A;
         4'hB: pattern = SEG_HEX_B;
         4'hC: pattern = SEG_HEX_C;
         4'hD: pattern = SEG_HEX_D;
         4'hE: pattern = SEG_HEX_E;
         4'hF: pattern = SEG_HEX_F;
         default: pattern = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_display_scan.sv
// Tear-free time-multiplexed 8-digit seven-segment scan driver.
module seg7_display_scan
   import seg7_display_scan_pkg::*;
#(
   parameter int CLK_DIV = SCAN_DIV_DEFAULT,
   parameter int DIGITS  = SCAN_DIGITS
) (
   input  logic                clk,
   input  logic                rst,
   seg7_display_scan_if.slave  bus
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       idx;
   logic [31:0]      snap_data;
   logic [7:0]       snap_dp;
   logic             load_pending;
   logic             tick;
   logic             frame_edge;
   logic [3:0]       nibble;
   logic [6:0]       glyph;
   logic             blank;
   logic [7:0]       an_q;
   logic [6:0]       seg_q;
   logic             dp_q;
   logic             frame_done_q;

   assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign frame_edge = tick && (idx == 3'(DIGITS - 1));
   assign nibble     = snap_data[{idx, 2'b00} +: 4];
   assign blank      = lz_blank(snap_data, idx, bus.blank_lz);

   seg7_hex_decoder u_dec (
      .nibble  (nibble),
      .pattern (glyph)
   );

   // Dwell prescaler and digit index
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every register see pre-edge values, like real flops.
      if (rst) begin
         div_cnt <= '0;
         idx     <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) idx <= (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
      end
   end

   // Frame snapshot: load only at a frame boundary or once after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_data    <= '0;
         snap_dp      <= '0;
         load_pending <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         load_pending <= 1'b0;
         frame_done_q <= frame_edge;
         if (frame_edge || load_pending) begin
            snap_data <= bus.display_data;
            snap_dp   <= bus.dp_mask;
         end
      end
   end

   // Registered pin drive for the current digit
   always_ff @(posedge clk) begin
      if (rst || blank) begin
         an_q  <= AN_OFF;
         seg_q <= SEG_BLANK;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= ~(8'd1 << idx);
         seg_q <= glyph;
         dp_q  <= ~snap_dp[idx];
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: doc/seg7_display_scan.md
Name: seg7_display_scan

Overview:
- Time-multiplexed 8-digit seven-segment driver. It consumes the 32-bit display register produced by the memory-mapped I/O block (display_C) and the companion decimal-point mask.
- Snapshots the value once per scan frame so a single frame never mixes old and new digits (tear-free).
- Scans one digit at a time and drives the board's active-low anode and cathode pins.
- Sits between the I/O memory block and the top-level FPGA pins.

Parameters:
- CLK_DIV, 50000: clock cycles each digit is lit (dwell time); legal range 2..2^20.
- DIGITS, 8: number of digits scanned; fixed at 8 to match the 32-bit display word.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- display_data  input  32  hex value to show; nibble i is shown on digit i (digit 0 is rightmost)
- dp_mask  input  8  bit i=1 lights the decimal point of digit i
- blank_lz  input  1  1 = blank leading-zero digits
- an  output  8  digit anodes, active-low, one-hot-low while lit
- seg  output  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}
- dp  output  1  decimal-point cathode, active-low
- frame_done  output  1  one-cycle pulse when a new snapshot is taken at a frame boundary

Behaviour:
- Reset (rst=1 at a clk edge), all synchronous:
  - Registers: div_cnt=0, idx=0, snap_data=0, snap_dp=0, load_pending=1.
  - Outputs: an=8'hFF, seg=7'h7F, dp=1, frame_done=0.
- Reset asserted mid-scan aborts the scan immediately. No partial digit survives.
- Prescaler:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - tick=1 exactly when div_cnt==CLK_DIV-1.
- Digit index: on tick, idx advances by 1 and wraps from DIGITS-1 to 0. Otherwise idx holds.
- Snapshot:
  - snap_data and snap_dp load from display_data and dp_mask when tick and idx==DIGITS-1 (frame boundary). frame_done=1 in the cycle after that edge.
  - First cycle after reset release: load_pending=1 forces one snapshot load with no frame_done pulse, then clears load_pending.
  - Input changes at any other time have no visible effect until the next frame boundary.
- Leading-zero blanking: digit i (i>=1) is blanked when blank_lz=1 and nibbles i..7 of snap_data are all zero. Digit 0 is never blanked.
- Output stage (registered, 1-cycle latency from idx/snap_data):
  - Lit digit: an = ~(1<<idx), seg = hex pattern of nibble idx, dp = ~snap_dp[idx].
  - Blanked digit: an=8'hFF, seg=7'h7F, dp=1.
- Hex patterns (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Never more than one anode low in any cycle.
- Full frame period: DIGITS*CLK_DIV cycles.

Decomposition:
- Shared definitions file additions:
  - SEG_BLANK (7'h7F), AN_OFF (8'hFF)
  - the 16 hex segment constants
  - SCAN_DIV_DEFAULT
- One natural combinational sub-module: seg7_hex_decoder (4-bit nibble in, 7-bit active-low pattern out), instantiated once on the selected nibble.

Test Plan (CLK_DIV=4):
1. Reset hold then release with display_data=32'h12345678, dp_mask=0, blank_lz=0:
   - During reset: an=FF, seg=7F.
   - Cycle 2 after release: an=FE, seg=0000000 ('8').
   - After 4 cycles: an=FD, seg=1111000 ('7').
   - After 32 cycles: back to an=FE.
2. Tear-free update: change display_data to 32'hFFFFFFFF while idx=3.
   - Digits 4..7 still show 4,3,2,1.
   - After frame_done, digit 0 shows seg=0001110.
   - frame_done pulse width is exactly 1 cycle, every 32 cycles.
3. blank_lz=1, display_data=32'h00000A05:
   - Digits 3..7 give an=FF, seg=7F.
   - Digit 2 shows 'A' (0001000), digit 1 shows '0' (1000000).
4. blank_lz=1, display_data=0: only digit 0 lights (an=FE, seg=1000000); digits 1..7 are blank.
5. dp_mask=8'h81: dp=0 only while an=FE or an=7F; dp=1 otherwise.
6. Assert rst for 1 cycle mid-frame (idx=5): next cycle an=FF, seg=7F. Scanning restarts at digit 0 with a fresh snapshot and no frame_done pulse.
